// File: rtl/piso_serial_tx.sv
// Framed parallel-in/serial-out transmitter: start bit (0), WIDTH data bits LSB first,
// STOP_BITS stop bits (1). The line idles high and advances only on clock edges with En=1.
module piso_serial_tx #(
    parameter int WIDTH     = 8,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             En,
    output logic             Q,
    output logic             notQ,
    output logic             busy,
    output logic             done
);

    // A one-bit floor keeps the counters legal when WIDTH is 1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    stop_cnt;

    assign shifted = shreg >> 1;
    assign notQ    = ~Q;

    // Q, load_ready, busy and done are all updated on the same edge as the state change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            Q          <= 1'b1;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid && load_ready) begin
                        shreg      <= load_data;
                        state      <= START;
                        Q          <= 1'b0;
                        load_ready <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                START: begin
                    if (En) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        Q       <= shreg[0];
                    end
                end
                DATA: begin
                    if (En) begin
                        shreg <= shifted;
                        if (bit_cnt == LAST_BIT) begin
                            state    <= STOP;
                            stop_cnt <= '0;
                            Q        <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            Q       <= shifted[0];
                        end
                    end
                end
                STOP: begin
                    if (En) begin
                        if (stop_cnt == LAST_STOP) begin
                            state      <= IDLE;
                            done       <= 1'b1;
                            load_ready <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed bench for piso_serial_tx: a per-cycle vector table for reset and a plain frame,
// then hand-written sequences for strobed, back-to-back, ignored-load and mid-frame reset cases.
module tb_piso_serial_tx;

    logic       clk;
    logic       rst_n;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic       En;
    logic       Q;
    logic       notQ;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    piso_serial_tx #(.WIDTH(8), .STOP_BITS(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .En         (En),
        .Q          (Q),
        .notQ       (notQ),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       lv;
        logic [7:0] data;
        logic       en;
        logic       q;
        logic       rdy;
        logic       bsy;
        logic       dn;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic q, input logic rdy,
                             input logic bsy, input logic dn);
        check({tag, ".Q"}, Q, q);
        check({tag, ".notQ"}, notQ, ~q);
        check({tag, ".load_ready"}, load_ready, rdy);
        check({tag, ".busy"}, busy, bsy);
        check({tag, ".done"}, done, dn);
    endtask

    // Expected line level at position idx of a frame: 0 start, 1..8 data LSB first, then stop.
    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        return 1'b1;
    endfunction

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        En         = 1'b0;

        // Reset with load_valid high, then one A5 frame with En always high.
        vecs[0] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        #2;
        for (int i = 0; i < 14; i++) begin
            rst_n      = vecs[i].rst_n;
            load_valid = vecs[i].lv;
            load_data  = vecs[i].data;
            En         = vecs[i].en;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].rdy, vecs[i].bsy, vecs[i].dn);
        end

        // Strobed: accept 3C with En low, then En on every 4th clock.
        load_valid = 1'b1;
        load_data  = 8'h3C;
        En         = 1'b0;
        tick();
        check_all("strobe.accept", 1'b0, 1'b0, 1'b1, 1'b0);
        load_valid = 1'b0;
        load_data  = 8'h00;
        for (int k = 1; k <= 40; k++) begin
            En = ((k % 4) == 0);
            tick();
            if (k < 40)
                check_all($sformatf("strobe.k%0d", k), frame_bit(8'h3C, k / 4), 1'b0, 1'b1, 1'b0);
            else
                check_all("strobe.end", 1'b1, 1'b1, 1'b0, 1'b1);
        end
        En = 1'b1;
        tick();

        // Back-to-back FF then 00 with load_valid held high.
        load_valid = 1'b1;
        load_data  = 8'hFF;
        for (int k = 0; k <= 21; k++) begin
            logic eq;
            logic hand;
            tick();
            if (k == 0) load_data = 8'h00;
            hand = (k == 10) || (k == 21);
            if (k <= 10) eq = frame_bit(8'hFF, k);
            else         eq = frame_bit(8'h00, k - 11);
            if (k == 21) eq = 1'b1;
            check_all($sformatf("b2b.k%0d", k), eq, hand, ~hand, hand);
        end
        load_valid = 1'b0;
        tick();
        check_all("b2b.idle", 1'b1, 1'b1, 1'b0, 1'b0);

        // A load pulse of 12 mid-frame must not disturb a C3 frame.
        load_valid = 1'b1;
        load_data  = 8'hC3;
        for (int k = 0; k <= 11; k++) begin
            tick();
            load_valid = (k == 2);
            load_data  = (k == 2) ? 8'h12 : 8'h00;
            if (k <= 9)
                check_all($sformatf("ign.k%0d", k), frame_bit(8'hC3, k), 1'b0, 1'b1, 1'b0);
            else if (k == 10)
                check_all("ign.done", 1'b1, 1'b1, 1'b0, 1'b1);
            else
                check_all("ign.idle", 1'b1, 1'b1, 1'b0, 1'b0);
        end

        // Reset during data bit 3 of 81, then a clean 5A frame.
        load_valid = 1'b1;
        load_data  = 8'h81;
        for (int k = 0; k <= 4; k++) begin
            tick();
            load_valid = 1'b0;
            check_all($sformatf("rst.k%0d", k), frame_bit(8'h81, k), 1'b0, 1'b1, 1'b0);
        end
        rst_n = 1'b0;
        tick();
        check_all("rst.edge", 1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check_all($sformatf("rst.after%0d", k), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        load_valid = 1'b1;
        load_data  = 8'h5A;
        for (int k = 0; k <= 10; k++) begin
            tick();
            load_valid = 1'b0;
            if (k <= 9)
                check_all($sformatf("clean.k%0d", k), frame_bit(8'h5A, k), 1'b0, 1'b1, 1'b0);
            else
                check_all("clean.done", 1'b1, 1'b1, 1'b0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
